// File: rtl/alu_seq_nzcv.sv
// Registered execute-stage ALU: ARM data-processing opcodes in one cycle,
// iterative shift-add multiply over WIDTH cycles, architectural NZCV register.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for an operation; in_ready high
// MRUN   | multiplier iterating, one multiplier bit per cycle (LSB first)
// DONE   | result/out_wb/flags held; out_valid high until out_ready
module alu_seq_nzcv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             mul,
    input  logic             s_bit,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_wb,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MRUN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic               r_mul_s;
    logic [WIDTH-1:0]   r_result;
    logic               r_out_wb;
    logic [3:0]         r_flags;

    logic [WIDTH-1:0]   w_opa;
    logic [WIDTH-1:0]   w_opb;
    logic               w_cin;
    logic               w_arith;
    logic [WIDTH-1:0]   w_logic;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_v;
    logic               w_cmp;
    logic               w_set;
    logic [3:0]         w_alu_flags;
    logic [WIDTH-1:0]   w_acc_next;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign out_wb    = r_out_wb;
    assign flags     = r_flags;

    // Operand routing: swap for reverse subtracts, invert the addend for subtracts,
    // carry-in from the flag register for the with-carry forms.
    always_comb begin
        w_opa   = a;
        w_opb   = b;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        w_logic = '0;
        case (op)
            OP_SUB, OP_CMP: begin w_opb = ~b; w_cin = 1'b1; end
            OP_RSB:         begin w_opa = b; w_opb = ~a; w_cin = 1'b1; end
            OP_ADD, OP_CMN: begin w_cin = 1'b0; end
            OP_ADC:         begin w_cin = r_flags[1]; end
            OP_SBC:         begin w_opb = ~b; w_cin = r_flags[1]; end
            OP_RSC:         begin w_opa = b; w_opb = ~a; w_cin = r_flags[1]; end
            OP_AND, OP_TST: begin w_arith = 1'b0; w_logic = a & b; end
            OP_EOR, OP_TEQ: begin w_arith = 1'b0; w_logic = a ^ b; end
            OP_ORR:         begin w_arith = 1'b0; w_logic = a | b; end
            OP_MOV:         begin w_arith = 1'b0; w_logic = b; end
            OP_BIC:         begin w_arith = 1'b0; w_logic = a & ~b; end
            OP_MVN:         begin w_arith = 1'b0; w_logic = ~b; end
            default:        begin w_arith = 1'b0; w_logic = '0; end
        endcase
    end

    // One adder serves every arithmetic opcode; bit WIDTH is the ARM carry (NOT borrow).
    assign w_sum     = {1'b0, w_opa} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
    assign w_alu_res = w_arith ? w_sum[MSB:0] : w_logic;
    assign w_v       = (w_opa[MSB] == w_opb[MSB]) & (w_sum[MSB] != w_opa[MSB]);
    assign w_cmp     = (op[3:2] == 2'b10);
    assign w_set     = s_bit | w_cmp;
    assign w_alu_flags = w_arith ? {w_alu_res[MSB], (w_alu_res == '0), w_sum[WIDTH], w_v}
                                 : {w_alu_res[MSB], (w_alu_res == '0), r_flags[1:0]};

    // Multiplier step: conditionally add the shifted multiplicand.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Control FSM with datapath registers; flags commit only on entry to DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_mul_s  <= 1'b0;
            r_result <= '0;
            r_out_wb <= 1'b0;
            r_flags  <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (mul) begin
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_acc    <= '0;
                            r_mul_s  <= s_bit;
                            r_cnt    <= CNT_W'(WIDTH - 1);
                            r_state  <= S_MRUN;
                        end else begin
                            r_result <= w_alu_res;
                            r_out_wb <= ~w_cmp;
                            if (w_set) r_flags <= w_alu_flags;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_MRUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == '0) begin
                        r_result <= w_acc_next;
                        r_out_wb <= 1'b1;
                        if (r_mul_s) r_flags[3:2] <= {w_acc_next[MSB], (w_acc_next == '0)};
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_nzcv.sv
module tb_alu_seq_nzcv;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'b0000;
    logic        mul = 1'b0;
    logic        s_bit = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        out_wb;
    logic [3:0]  flags;

    int n_pass  = 0;
    int n_total = 0;

    alu_seq_nzcv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .mul(mul), .s_bit(s_bit), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_wb(out_wb), .flags(flags)
    );

    always #5 clk = ~clk;

    // Present one op in IDLE, return 1 time unit after the accept edge.
    task automatic issue(input logic [3:0] t_op, input logic t_mul, input logic t_s,
                         input logic [31:0] t_a, input logic [31:0] t_b);
        @(negedge clk);
        op = t_op; mul = t_mul; s_bit = t_s; a = t_a; b = t_b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h0BADF00D; op = 4'b1111;
    endtask

    task automatic retire();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (result !== 32'h0 || out_wb !== 1'b0) $display("FAIL reset_result got %h/%b exp 00000000/0", result, out_wb); else n_pass++;
        n_total++; if (flags !== 4'b0000 || out_valid !== 1'b0) $display("FAIL reset_flags got %b/%b exp 0000/0", flags, out_valid); else n_pass++;
        @(negedge clk); reset_n = 1'b1; #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_add_overflow();
        issue(4'b0100, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h00000001);
        n_total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL add_latency got ov=%b ir=%b exp ov=1 ir=0", out_valid, in_ready); else n_pass++;
        n_total++; if (result !== 32'h80000000 || out_wb !== 1'b1) $display("FAIL add_result got %h/%b exp 80000000/1", result, out_wb); else n_pass++;
        n_total++; if (flags !== 4'b1001) $display("FAIL add_flags got %b exp 1001", flags); else n_pass++;
        retire();
    endtask

    task automatic test_cmp_sub();
        issue(4'b1010, 1'b0, 1'b0, 32'd5, 32'd5);
        n_total++; if (out_wb !== 1'b0 || flags !== 4'b0110) $display("FAIL cmp got wb=%b flags=%b exp wb=0 flags=0110", out_wb, flags); else n_pass++;
        retire();
        issue(4'b0010, 1'b0, 1'b1, 32'd3, 32'd5);
        n_total++; if (result !== 32'hFFFFFFFE || flags !== 4'b1000) $display("FAIL sub got %h/%b exp FFFFFFFE/1000", result, flags); else n_pass++;
        retire();
        issue(4'b0011, 1'b0, 1'b1, 32'd1, 32'd10);
        n_total++; if (result !== 32'd9 || flags !== 4'b0010) $display("FAIL rsb got %h/%b exp 00000009/0010", result, flags); else n_pass++;
        retire();
    endtask

    task automatic test_carry_chain();
        issue(4'b0100, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001);
        n_total++; if (result !== 32'h0 || flags !== 4'b0110) $display("FAIL add_carry got %h/%b exp 00000000/0110", result, flags); else n_pass++;
        retire();
        issue(4'b0101, 1'b0, 1'b1, 32'd2, 32'd3);
        n_total++; if (result !== 32'd6 || flags !== 4'b0000) $display("FAIL adc got %h/%b exp 00000006/0000", result, flags); else n_pass++;
        retire();
        issue(4'b0110, 1'b0, 1'b1, 32'd6, 32'd6);
        n_total++; if (result !== 32'hFFFFFFFF || flags !== 4'b1000) $display("FAIL sbc got %h/%b exp FFFFFFFF/1000", result, flags); else n_pass++;
        retire();
    endtask

    task automatic test_mul();
        bit busy_ok;
        issue(4'b0100, 1'b0, 1'b1, 32'h80000000, 32'h80000000);
        n_total++; if (flags !== 4'b0111) $display("FAIL mul_setup got %b exp 0111", flags); else n_pass++;
        retire();
        issue(4'b0000, 1'b1, 1'b1, 32'h0000FFFF, 32'h0000FFFF);
        busy_ok = (out_valid === 1'b0) && (in_ready === 1'b0);
        for (int i = 1; i < 32; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) busy_ok = 1'b0;
        end
        n_total++; if (!busy_ok) $display("FAIL mul_busy got early out_valid or in_ready exp low for 31 edges"); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (out_valid !== 1'b1) $display("FAIL mul_latency got %b exp 1 at edge 32", out_valid); else n_pass++;
        n_total++; if (result !== 32'hFFFE0001 || flags !== 4'b1011) $display("FAIL mul_result got %h/%b exp FFFE0001/1011", result, flags); else n_pass++;
        retire();
    endtask

    task automatic test_logic();
        issue(4'b1111, 1'b0, 1'b1, 32'h0, 32'h0);
        n_total++; if (result !== 32'hFFFFFFFF || flags !== 4'b1011) $display("FAIL mvn got %h/%b exp FFFFFFFF/1011", result, flags); else n_pass++;
        retire();
        issue(4'b0001, 1'b0, 1'b1, 32'd5, 32'd5);
        n_total++; if (result !== 32'h0 || flags !== 4'b0111) $display("FAIL eor got %h/%b exp 00000000/0111", result, flags); else n_pass++;
        retire();
        issue(4'b1110, 1'b0, 1'b0, 32'hFF, 32'h0F);
        n_total++; if (result !== 32'hF0 || flags !== 4'b0111) $display("FAIL bic_nos got %h/%b exp 000000F0/0111", result, flags); else n_pass++;
        retire();
    endtask

    task automatic test_back_to_back();
        bit hold_ok = 1'b1;
        issue(4'b1100, 1'b0, 1'b1, 32'hF0, 32'h0F);
        n_total++; if (result !== 32'hFF || flags !== 4'b0011) $display("FAIL orr got %h/%b exp 000000FF/0011", result, flags); else n_pass++;
        @(negedge clk);
        op = 4'b0100; mul = 1'b0; s_bit = 1'b1; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (result !== 32'hFF || flags !== 4'b0011 || out_valid !== 1'b1 || in_ready !== 1'b0) hold_ok = 1'b0;
        end
        n_total++; if (!hold_ok) $display("FAIL done_hold got %h/%b ov=%b exp 000000FF/0011 ov=1", result, flags, out_valid); else n_pass++;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'hFF) $display("FAIL bubble got ov=%b ir=%b res=%h exp 0/1/000000FF", out_valid, in_ready, result); else n_pass++;
        @(posedge clk); #1; in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1 || result !== 32'd2 || flags !== 4'b0000) $display("FAIL next_accept got ov=%b %h/%b exp 1 00000002/0000", out_valid, result, flags); else n_pass++;
        retire();
    endtask

    task automatic test_reset_mul();
        bit busy_ok;
        issue(4'b0000, 1'b1, 1'b1, 32'h12345678, 32'h00005678);
        repeat (9) @(posedge clk);
        #2; reset_n = 1'b0; #1;
        n_total++; if (result !== 32'h0 || flags !== 4'b0000 || out_valid !== 1'b0 || out_wb !== 1'b0) $display("FAIL async_reset got %h/%b ov=%b wb=%b exp all 0", result, flags, out_valid, out_wb); else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        issue(4'b0000, 1'b1, 1'b1, 32'd3, 32'd7);
        busy_ok = (out_valid === 1'b0);
        for (int i = 1; i < 32; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) busy_ok = 1'b0;
        end
        n_total++; if (!busy_ok) $display("FAIL mul2_busy got early out_valid exp low for 31 edges"); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (out_valid !== 1'b1 || result !== 32'd21 || flags !== 4'b0000) $display("FAIL mul2_result got ov=%b %h/%b exp 1 00000015/0000", out_valid, result, flags); else n_pass++;
        retire();
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_cmp_sub();
        test_carry_chain();
        test_mul();
        test_logic();
        test_back_to_back();
        test_reset_mul();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
